// File: rtl/scoreboard_scan_ctrl.sv
// Four-digit scoreboard controller: saturating BCD score counter, one-hot digit
// scan at a fixed refresh rate, and leading-zero blanking for the selected digit.
module scoreboard_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       score_inc,
    input  logic       score_clr,
    output logic [3:0] code,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic       blank,
    output logic       sat
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] TERM = PW'(SCAN_DIV - 1);

    typedef enum logic [3:0] {
        SEL_D0 = 4'b0001,
        SEL_D1 = 4'b0010,
        SEL_D2 = 4'b0100,
        SEL_D3 = 4'b1000
    } sel_e;

    sel_e          code_q;
    logic [PW-1:0] presc_q;
    logic [3:0]    d0_q, d1_q, d2_q, d3_q;
    logic [3:0]    d0_d, d1_d, d2_d, d3_d;
    logic          sat_w;

    assign sat_w = (d3_q == 4'd9) && (d2_q == 4'd9) && (d1_q == 4'd9) && (d0_q == 4'd9);

    // Ripple the decimal carry through all four digits within one cycle.
    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latch).
        d0_d = d0_q;
        d1_d = d1_q;
        d2_d = d2_q;
        d3_d = d3_q;
        if (score_clr) begin
            d0_d = 4'd0;
            d1_d = 4'd0;
            d2_d = 4'd0;
            d3_d = 4'd0;
        end else if (score_inc && !sat_w) begin
            if (d0_q != 4'd9) begin
                d0_d = d0_q + 4'd1;
            end else begin
                d0_d = 4'd0;
                if (d1_q != 4'd9) begin
                    d1_d = d1_q + 4'd1;
                end else begin
                    d1_d = 4'd0;
                    if (d2_q != 4'd9) begin
                        d2_d = d2_q + 4'd1;
                    end else begin
                        d2_d = 4'd0;
                        d3_d = d3_q + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            d0_q <= 4'd0;
            d1_q <= 4'd0;
            d2_q <= 4'd0;
            d3_q <= 4'd0;
        end else begin
            d0_q <= d0_d;
            d1_q <= d1_d;
            d2_q <= d2_d;
            d3_q <= d3_d;
        end
    end

    // Scan prescaler and digit-select rotation; independent of score activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            code_q  <= SEL_D0;
        end else if (presc_q == TERM) begin
            presc_q <= '0;
            case (code_q)
                SEL_D0:  code_q <= SEL_D1;
                SEL_D1:  code_q <= SEL_D2;
                SEL_D2:  code_q <= SEL_D3;
                default: code_q <= SEL_D0;
            endcase
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    always_comb begin
        case (code_q)
            SEL_D3:  blank = (d3_q == 4'd0);
            SEL_D2:  blank = (d3_q == 4'd0) && (d2_q == 4'd0);
            SEL_D1:  blank = (d3_q == 4'd0) && (d2_q == 4'd0) && (d1_q == 4'd0);
            default: blank = 1'b0;
        endcase
    end

    assign code = code_q;
    assign d0   = d0_q;
    assign d1   = d1_q;
    assign d2   = d2_q;
    assign d3   = d3_q;
    assign sat  = sat_w;

endmodule

// File: tb/tb_scoreboard_scan_ctrl.sv
// Directed bench for scoreboard_scan_ctrl: one instance at SCAN_DIV=4, one at
// SCAN_DIV=3 for the rotation test; both share clock, reset and score inputs.
module tb_scoreboard_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       score_inc = 1'b0;
    logic       score_clr = 1'b0;
    logic [3:0] code, d0, d1, d2, d3;
    logic       blank, sat;
    logic [3:0] code3, e0, e1, e2, e3;
    logic       blank3, sat3;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    scoreboard_scan_ctrl #(.SCAN_DIV(4)) u_dut (
        .clk(clk), .rst(rst), .score_inc(score_inc), .score_clr(score_clr),
        .code(code), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .blank(blank), .sat(sat)
    );

    scoreboard_scan_ctrl #(.SCAN_DIV(3)) u_dut3 (
        .clk(clk), .rst(rst), .score_inc(score_inc), .score_clr(score_clr),
        .code(code3), .d0(e0), .d1(e1), .d2(e2), .d3(e3), .blank(blank3), .sat(sat3)
    );

    function automatic logic [15:0] score();
        return {d3, d2, d1, d0};
    endfunction

    // Expected select code after k edges since reset release.
    function automatic logic [3:0] exp_code(int k, int div);
        logic [3:0] one;
        one = 4'b0001;
        return one << ((k / div) % 4);
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        score_inc = 1'b0;
        score_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if (code !== 4'b0001 || score() !== 16'h0000 || blank !== 1'b0 || sat !== 1'b0) begin
            n_err++;
            $display("FAIL reset_initial: code=%b score=%h blank=%b sat=%b, want 0001 0000 0 0",
                     code, score(), blank, sat);
        end
        rst = 1'b0;
        cyc = 0;
        score_inc = 1'b1;
        repeat (123) tick();
        score_inc = 1'b0;
        repeat (2) tick();
        n_vec++;
        if (score() !== 16'h0123) begin
            n_err++;
            $display("FAIL reset_preload: score=%h want 0123", score());
        end
        // Assert reset between edges and look before any further clock edge.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (code !== 4'b0001 || score() !== 16'h0000 || blank !== 1'b0 || sat !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: code=%b score=%h blank=%b sat=%b, want 0001 0000 0 0",
                     code, score(), blank, sat);
        end
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        repeat (3) tick();
        n_vec++;
        if (code !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_edge3: code=%b want 0001", code);
        end
        tick();
        n_vec++;
        if (code !== 4'b0010) begin
            n_err++;
            $display("FAIL reset_edge4: code=%b want 0010", code);
        end
    endtask

    task automatic test_carry();
        do_reset();
        score_inc = 1'b1;
        repeat (9) tick();
        score_inc = 1'b0;
        tick();
        n_vec++;
        if (score() !== 16'h0009) begin
            n_err++;
            $display("FAIL carry_0009: score=%h want 0009", score());
        end
        score_inc = 1'b1;
        tick();
        score_inc = 1'b0;
        n_vec++;
        if (score() !== 16'h0010) begin
            n_err++;
            $display("FAIL carry_0010: score=%h want 0010", score());
        end
        score_inc = 1'b1;
        repeat (989) tick();
        score_inc = 1'b0;
        tick();
        n_vec++;
        if (score() !== 16'h0999) begin
            n_err++;
            $display("FAIL carry_0999: score=%h want 0999", score());
        end
        score_inc = 1'b1;
        tick();
        score_inc = 1'b0;
        n_vec++;
        if (score() !== 16'h1000 || sat !== 1'b0) begin
            n_err++;
            $display("FAIL carry_1000: score=%h sat=%b want 1000 0", score(), sat);
        end
    endtask

    task automatic test_back_to_back();
        score_inc = 1'b1;
        repeat (3) tick();
        score_inc = 1'b0;
        n_vec++;
        if (score() !== 16'h1003) begin
            n_err++;
            $display("FAIL b2b_burst: score=%h want 1003", score());
        end
        for (int i = 0; i < 6; i++) begin
            score_inc = i[0] ? 1'b0 : 1'b1;
            tick();
        end
        score_inc = 1'b0;
        n_vec++;
        if (score() !== 16'h1006) begin
            n_err++;
            $display("FAIL b2b_alternate: score=%h want 1006", score());
        end
    endtask

    task automatic test_saturation();
        do_reset();
        score_inc = 1'b1;
        for (int i = 1; i <= 10005; i++) begin
            tick();
            if (i == 1234) begin
                n_vec++;
                if (score() !== 16'h1234 || sat !== 1'b0) begin
                    n_err++;
                    $display("FAIL sat_mid: score=%h sat=%b want 1234 0", score(), sat);
                end
            end
            if (i == 9998) begin
                n_vec++;
                if (score() !== 16'h9998 || sat !== 1'b0) begin
                    n_err++;
                    $display("FAIL sat_9998: score=%h sat=%b want 9998 0", score(), sat);
                end
            end
            if (i >= 9999) begin
                n_vec++;
                if (score() !== 16'h9999 || sat !== 1'b1) begin
                    n_err++;
                    $display("FAIL sat_hold cycle %0d: score=%h sat=%b want 9999 1", i, score(), sat);
                end
            end
        end
        score_inc = 1'b0;
        tick();
        n_vec++;
        if (score() !== 16'h9999 || sat !== 1'b1) begin
            n_err++;
            $display("FAIL sat_idle: score=%h sat=%b want 9999 1", score(), sat);
        end
        score_clr = 1'b1;
        score_inc = 1'b1;
        tick();
        score_clr = 1'b0;
        score_inc = 1'b0;
        n_vec++;
        if (score() !== 16'h0000 || sat !== 1'b0) begin
            n_err++;
            $display("FAIL sat_clear: score=%h sat=%b want 0000 0", score(), sat);
        end
    endtask

    // Observe one frame at SCAN_DIV=4; blank expectations indexed by digit slot 0..3.
    task automatic check_frame(input string tag, input logic [3:0] want_blank);
        for (int i = 0; i < 16; i++) begin
            tick();
            n_vec++;
            if (code !== exp_code(cyc, 4)) begin
                n_err++;
                $display("FAIL %s_code cycle %0d: code=%b want %b", tag, cyc, code, exp_code(cyc, 4));
            end
            n_vec++;
            if (blank !== want_blank[(cyc / 4) % 4]) begin
                n_err++;
                $display("FAIL %s_blank code=%b: blank=%b want %b", tag, code, blank,
                         want_blank[(cyc / 4) % 4]);
            end
        end
    endtask

    task automatic test_blanking_and_clear();
        do_reset();
        score_inc = 1'b1;
        repeat (42) tick();
        score_inc = 1'b0;
        n_vec++;
        if (score() !== 16'h0042) begin
            n_err++;
            $display("FAIL blank_preload: score=%h want 0042", score());
        end
        check_frame("blank42", 4'b1100);
        score_clr = 1'b1;
        score_inc = 1'b1;
        tick();
        score_clr = 1'b0;
        score_inc = 1'b0;
        n_vec++;
        if (score() !== 16'h0000 || sat !== 1'b0 || code !== exp_code(cyc, 4)) begin
            n_err++;
            $display("FAIL clr_priority: score=%h sat=%b code=%b want 0000 0 %b",
                     score(), sat, code, exp_code(cyc, 4));
        end
        check_frame("blank00", 4'b1110);
    endtask

    task automatic test_scan_rotation();
        do_reset();
        for (int i = 0; i < 24; i++) begin
            tick();
            n_vec++;
            if (code3 !== exp_code(cyc, 3) || !$onehot(code3)) begin
                n_err++;
                $display("FAIL scan3 cycle %0d: code=%b want %b", cyc, code3, exp_code(cyc, 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_back_to_back();
        test_saturation();
        test_blanking_and_clear();
        test_scan_rotation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
